// File: rtl/adc_pkg.sv
// Shared constants, FSM encoding and frame-address helper for the serial ADC scan sequencer.
package adc_pkg;

   localparam int ADC_NUM_CH         = 8;
   localparam int ADC_CH_W           = 3;
   localparam int ADC_DATA_W         = 12;
   localparam int ADC_FRAME_BITS     = 16;
   localparam int ADC_ADDR_FIRST_BIT = 2;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_CS_SETUP = 3'd1,
      ST_SCLK_LO  = 3'd2,
      ST_SCLK_HI  = 3'd3,
      ST_CS_HOLD  = 3'd4,
      ST_GAP      = 3'd5
   } adc_state_e;

   // DIN value for frame bit k: the channel address sits MSB first in bits 2..4.
   function automatic logic addr_bit(input logic [ADC_CH_W-1:0] ch, input logic [3:0] k);
      logic v;
      v = 1'b0;
      if (k == 4'(ADC_ADDR_FIRST_BIT)) begin
         v = ch[2];
      end else if (k == 4'(ADC_ADDR_FIRST_BIT + 1)) begin
         v = ch[1];
      end else if (k == 4'(ADC_ADDR_FIRST_BIT + 2)) begin
         v = ch[0];
      end else begin
         v = 1'b0;
      end
      return v;
   endfunction

endpackage

// File: rtl/adc_scan_ctrl_if.sv
// ADC pin bundle plus the tagged sample strobe toward user logic.
interface adc_scan_ctrl_if;
   import adc_pkg::*;

   logic                  ADC_CS_N;
   logic                  ADC_SCLK;
   logic                  ADC_SADDR;
   logic                  ADC_SDAT;
   logic                  sample_valid;
   logic [ADC_CH_W-1:0]   sample_ch;
   logic [ADC_DATA_W-1:0] sample_data;

   modport master (
      output ADC_CS_N, ADC_SCLK, ADC_SADDR,
      input  ADC_SDAT,
      output sample_valid, sample_ch, sample_data
   );

   modport slave (
      input  ADC_CS_N, ADC_SCLK, ADC_SADDR,
      output ADC_SDAT,
      input  sample_valid, sample_ch, sample_data
   );

endinterface

// File: rtl/adc_ch_sel.sv
// Round-robin finder: first set mask bit strictly after i_last, wrapping back to i_last itself.
module adc_ch_sel
   import adc_pkg::*;
(
   input  logic [ADC_NUM_CH-1:0] i_mask,
   input  logic [ADC_CH_W-1:0]   i_last,
   output logic [ADC_CH_W-1:0]   o_next,
   output logic                  o_any
);

   logic                w_found;
   logic [ADC_CH_W-1:0] w_idx;

   // Priority search starting one above the last served channel.
   always_comb begin
      o_next  = i_last;
      w_found = 1'b0;
      w_idx   = i_last;
      for (int i = 1; i <= ADC_NUM_CH; i++) begin
         w_idx = i_last + ADC_CH_W'(i);
         if (!w_found && i_mask[w_idx]) begin
            o_next  = w_idx;
            w_found = 1'b1;
         end else begin
            w_found = w_found;
         end
      end
   end

   assign o_any = |i_mask;

endmodule

// File: rtl/adc_scan_ctrl.sv
// Round-robin scan sequencer for an 8-channel 12-bit SPI ADC; one 16-bit frame per conversion,
// results are one frame late so the first frame after idle only primes the pipeline.
module adc_scan_ctrl
   import adc_pkg::*;
#(
   parameter int CLK_DIV = 16,
   parameter int CS_GAP  = 8
) (
   input  logic                  CLOCK_50,
   input  logic                  RESET,
   input  logic                  enable,
   input  logic [ADC_NUM_CH-1:0] ch_mask,
   output logic                  busy,
   adc_scan_ctrl_if.master       bus
);

   localparam int                CNT_W    = 16;
   localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]  DIV_LAST = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0]  GAP_LAST = CNT_W'(CS_GAP - 1);
   localparam logic [3:0]        LAST_BIT = 4'(ADC_FRAME_BITS - 1);

   adc_state_e                r_state,       w_state_nxt;
   logic [CNT_W-1:0]          r_cnt,         w_cnt_nxt;
   logic [3:0]                r_bit,         w_bit_nxt;
   logic [ADC_CH_W-1:0]       r_frame_ch,    w_frame_ch_nxt;
   logic [ADC_CH_W-1:0]       r_prev_ch,     w_prev_ch_nxt;
   logic [ADC_CH_W-1:0]       r_last_ch,     w_last_ch_nxt;
   logic                      r_prime,       w_prime_nxt;
   logic [ADC_FRAME_BITS-1:0] r_shift,       w_shift_nxt;
   logic                      r_cs_n,        w_cs_n_nxt;
   logic                      r_sclk,        w_sclk_nxt;
   logic                      r_saddr,       w_saddr_nxt;
   logic                      r_valid,       w_valid_nxt;
   logic [ADC_CH_W-1:0]       r_sample_ch,   w_sample_ch_nxt;
   logic [ADC_DATA_W-1:0]     r_sample_data, w_sample_data_nxt;
   logic                      r_busy;

   logic [ADC_CH_W-1:0]       w_next_ch;
   logic                      w_any;
   logic                      w_div_done;
   logic                      w_gap_done;

   adc_ch_sel u_ch_sel (
      .i_mask (ch_mask),
      .i_last (r_last_ch),
      .o_next (w_next_ch),
      .o_any  (w_any)
   );

   assign w_div_done = (r_cnt == DIV_LAST);
   assign w_gap_done = (r_cnt == GAP_LAST);

   // Next-state and next-output logic for the frame sequencer.
   always_comb begin
      w_state_nxt       = r_state;
      w_cnt_nxt         = r_cnt + 16'd1;
      w_bit_nxt         = r_bit;
      w_frame_ch_nxt    = r_frame_ch;
      w_prev_ch_nxt     = r_prev_ch;
      w_last_ch_nxt     = r_last_ch;
      w_prime_nxt       = r_prime;
      w_shift_nxt       = r_shift;
      w_cs_n_nxt        = r_cs_n;
      w_sclk_nxt        = r_sclk;
      w_saddr_nxt       = r_saddr;
      w_valid_nxt       = 1'b0;
      w_sample_ch_nxt   = r_sample_ch;
      w_sample_data_nxt = r_sample_data;
      case (r_state)
         ST_IDLE: begin
            w_cnt_nxt = CNT_ZERO;
            if (enable && w_any) begin
               w_state_nxt    = ST_CS_SETUP;
               w_frame_ch_nxt = w_next_ch;
               w_cs_n_nxt     = 1'b0;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_CS_SETUP: begin
            if (w_div_done) begin
               w_state_nxt = ST_SCLK_LO;
               w_cnt_nxt   = CNT_ZERO;
               w_bit_nxt   = 4'd0;
               w_sclk_nxt  = 1'b0;
               w_saddr_nxt = addr_bit(r_frame_ch, 4'd0);
            end else begin
               w_state_nxt = ST_CS_SETUP;
            end
         end
         ST_SCLK_LO: begin
            if (w_div_done) begin
               w_state_nxt                  = ST_SCLK_HI;
               w_cnt_nxt                    = CNT_ZERO;
               w_sclk_nxt                   = 1'b1;
               w_shift_nxt[LAST_BIT - r_bit] = bus.ADC_SDAT;
            end else begin
               w_state_nxt = ST_SCLK_LO;
            end
         end
         ST_SCLK_HI: begin
            if (w_div_done) begin
               w_cnt_nxt = CNT_ZERO;
               if (r_bit == LAST_BIT) begin
                  w_state_nxt = ST_CS_HOLD;
               end else begin
                  w_state_nxt = ST_SCLK_LO;
                  w_bit_nxt   = r_bit + 4'd1;
                  w_sclk_nxt  = 1'b0;
                  w_saddr_nxt = addr_bit(r_frame_ch, r_bit + 4'd1);
               end
            end else begin
               w_state_nxt = ST_SCLK_HI;
            end
         end
         ST_CS_HOLD: begin
            if (w_div_done) begin
               w_state_nxt = ST_GAP;
               w_cnt_nxt   = CNT_ZERO;
               w_cs_n_nxt  = 1'b1;
               w_saddr_nxt = 1'b0;
               // This frame carried the result for the address sent one frame earlier.
               if (!r_prime) begin
                  w_valid_nxt       = 1'b1;
                  w_sample_ch_nxt   = r_prev_ch;
                  w_sample_data_nxt = r_shift[ADC_DATA_W-1:0];
               end else begin
                  w_prime_nxt = 1'b0;
               end
               w_prev_ch_nxt = r_frame_ch;
               w_last_ch_nxt = r_frame_ch;
            end else begin
               w_state_nxt = ST_CS_HOLD;
            end
         end
         ST_GAP: begin
            if (w_gap_done) begin
               w_cnt_nxt = CNT_ZERO;
               if (enable && w_any) begin
                  w_state_nxt    = ST_CS_SETUP;
                  w_frame_ch_nxt = w_next_ch;
                  w_cs_n_nxt     = 1'b0;
               end else begin
                  w_state_nxt = ST_IDLE;
                  w_prime_nxt = 1'b1;
               end
            end else begin
               w_state_nxt = ST_GAP;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = CNT_ZERO;
            w_cs_n_nxt  = 1'b1;
            w_sclk_nxt  = 1'b1;
            w_saddr_nxt = 1'b0;
            w_prime_nxt = 1'b1;
         end
      endcase
   end

   // State and output registers; reset overrides any frame in progress.
   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         r_state       <= ST_IDLE;
         r_cnt         <= CNT_ZERO;
         r_bit         <= 4'd0;
         r_frame_ch    <= 3'd0;
         r_prev_ch     <= 3'd0;
         r_last_ch     <= 3'd7;
         r_prime       <= 1'b1;
         r_shift       <= 16'h0000;
         r_cs_n        <= 1'b1;
         r_sclk        <= 1'b1;
         r_saddr       <= 1'b0;
         r_valid       <= 1'b0;
         r_sample_ch   <= 3'd0;
         r_sample_data <= 12'h000;
         r_busy        <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_cnt         <= w_cnt_nxt;
         r_bit         <= w_bit_nxt;
         r_frame_ch    <= w_frame_ch_nxt;
         r_prev_ch     <= w_prev_ch_nxt;
         r_last_ch     <= w_last_ch_nxt;
         r_prime       <= w_prime_nxt;
         r_shift       <= w_shift_nxt;
         r_cs_n        <= w_cs_n_nxt;
         r_sclk        <= w_sclk_nxt;
         r_saddr       <= w_saddr_nxt;
         r_valid       <= w_valid_nxt;
         r_sample_ch   <= w_sample_ch_nxt;
         r_sample_data <= w_sample_data_nxt;
         r_busy        <= (w_state_nxt != ST_IDLE);
      end
   end

   assign bus.ADC_CS_N     = r_cs_n;
   assign bus.ADC_SCLK     = r_sclk;
   assign bus.ADC_SADDR    = r_saddr;
   assign bus.sample_valid = r_valid;
   assign bus.sample_ch    = r_sample_ch;
   assign bus.sample_data  = r_sample_data;
   assign busy             = r_busy;

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Scoreboard bench: a fast instance (CLK_DIV=2, CS_GAP=3) with a behavioural ADC, and a default instance for timing.
module tb_adc_scan_ctrl;

   typedef struct packed {
      logic [2:0]  ch;
      logic [11:0] data;
   } smp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       en_f, en_d;
   logic [7:0] mask_f, mask_d;
   logic       busy_f, busy_d;
   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   adc_scan_ctrl_if fa ();
   adc_scan_ctrl_if fd ();

   adc_scan_ctrl #(.CLK_DIV(2), .CS_GAP(3)) u_fast (
      .CLOCK_50 (clk),
      .RESET    (rst),
      .enable   (en_f),
      .ch_mask  (mask_f),
      .busy     (busy_f),
      .bus      (fa)
   );

   adc_scan_ctrl u_def (
      .CLOCK_50 (clk),
      .RESET    (rst),
      .enable   (en_d),
      .ch_mask  (mask_d),
      .busy     (busy_d),
      .bus      (fd)
   );

   smp_t       exp_q[$];
   logic [2:0] addr_q[$];
   logic [2:0] dexp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ADC model: answers each frame with the result for the address received in the previous frame.
   int         f_k = 0;
   int         f_mode = 0;
   logic       f_sdat = 1'b0;
   logic [15:0] f_out = 16'h0000;
   logic [15:0] f_saddr = 16'h0000;
   logic [2:0]  f_pend = 3'd0;
   logic [2:0]  f_exp_addr;

   assign fa.ADC_SDAT = f_sdat;
   assign fd.ADC_SDAT = 1'b0;

   function automatic logic [11:0] f_data(input logic [2:0] p);
      if (f_mode == 0) return 12'hABC;
      else return 12'h100 + {9'd0, p};
   endfunction

   always @(negedge fa.ADC_CS_N) begin
      f_k     = 0;
      f_saddr = 16'h0000;
      f_out   = {4'h0, f_data(f_pend)};
   end

   always @(negedge fa.ADC_SCLK) begin
      if (fa.ADC_CS_N == 1'b0 && f_k < 16) begin
         f_sdat = f_out[15 - f_k];
         f_k    = f_k + 1;
      end
   end

   always @(posedge fa.ADC_SCLK) begin
      if (fa.ADC_CS_N == 1'b0 && f_k >= 1 && f_k <= 16) f_saddr[16 - f_k] = fa.ADC_SADDR;
   end

   always @(posedge fa.ADC_CS_N) begin
      if (f_k == 16) begin
         f_pend = f_saddr[13:11];
         checks++;
         if (addr_q.size() == 0) begin
            errors++;
            $display("FAIL addr_frame: unexpected frame, DIN word %h", f_saddr);
         end else begin
            f_exp_addr = addr_q.pop_front();
            if (f_saddr !== {2'b00, f_exp_addr, 11'd0}) begin
               errors++;
               $display("FAIL addr_frame: DIN word %h expected %h", f_saddr, {2'b00, f_exp_addr, 11'd0});
            end
         end
      end
   end

   // Strobe monitor for the fast instance.
   smp_t m_exp;
   always @(negedge clk) begin
      if (fa.sample_valid === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL fast_strobe: unexpected ch=%0d data=%h", fa.sample_ch, fa.sample_data);
         end else begin
            m_exp = exp_q.pop_front();
            if ({fa.sample_ch, fa.sample_data} !== m_exp) begin
               errors++;
               $display("FAIL fast_strobe: got ch=%0d data=%h expected ch=%0d data=%h",
                        fa.sample_ch, fa.sample_data, m_exp.ch, m_exp.data);
            end
         end
      end
   end

   // Strobe monitor for the default instance: channel order and spacing.
   int         d_last = -1;
   logic [2:0] d_exp;
   always @(negedge clk) begin
      if (fd.sample_valid === 1'b1) begin
         checks++;
         if (dexp_q.size() == 0) begin
            errors++;
            $display("FAIL def_strobe: unexpected ch=%0d", fd.sample_ch);
         end else begin
            d_exp = dexp_q.pop_front();
            if (fd.sample_ch !== d_exp) begin
               errors++;
               $display("FAIL def_strobe: got ch=%0d expected ch=%0d", fd.sample_ch, d_exp);
            end
         end
         if (d_last >= 0) begin
            checks++;
            if (cyc - d_last != 552) begin
               errors++;
               $display("FAIL def_spacing: got %0d clocks expected 552", cyc - d_last);
            end
         end
         d_last = cyc;
      end
   end

   task automatic wait_cs_falls(input bit which, input int n);
      int   seen = 0;
      int   cnt  = 0;
      logic prev, cur;
      prev = which ? fd.ADC_CS_N : fa.ADC_CS_N;
      while (seen < n && cnt < n * 2000) begin
         @(negedge clk);
         cnt++;
         cur = which ? fd.ADC_CS_N : fa.ADC_CS_N;
         if (prev === 1'b1 && cur === 1'b0) seen++;
         prev = cur;
      end
      chk("cs_fall_wait", seen, n);
   endtask

   task automatic wait_sclk_rises(input int n);
      int   seen = 0;
      int   cnt  = 0;
      logic prev;
      prev = fa.ADC_SCLK;
      while (seen < n && cnt < 1000) begin
         @(negedge clk);
         cnt++;
         if (prev === 1'b0 && fa.ADC_SCLK === 1'b1) seen++;
         prev = fa.ADC_SCLK;
      end
      chk("sclk_rise_wait", seen, n);
   endtask

   task automatic wait_idle(input bit which);
      int cnt = 0;
      while ((which ? busy_d : busy_f) !== 1'b0 && cnt < 2000) begin
         @(negedge clk);
         cnt++;
      end
      chk("busy_idle", which ? busy_d : busy_f, 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic chk_queues_empty();
      chk("addr_q_empty", addr_q.size(), 0);
      chk("exp_q_empty", exp_q.size(), 0);
   endtask

   int nf, t1, t2, budget, bad;
   logic prev_sclk;

   initial begin
      rst = 1'b1; en_f = 1'b0; en_d = 1'b0; mask_f = 8'h00; mask_d = 8'h00;
      repeat (4) @(negedge clk);
      chk("rst_cs_n", fa.ADC_CS_N, 1);
      chk("rst_sclk", fa.ADC_SCLK, 1);
      chk("rst_saddr", fa.ADC_SADDR, 0);
      chk("rst_busy", busy_f, 0);
      chk("rst_valid", fa.sample_valid, 0);
      chk("rst_sample_ch", fa.sample_ch, 0);
      chk("rst_sample_data", fa.sample_data, 0);

      // Released with enable low: pins must stay idle.
      rst = 1'b0; mask_f = 8'hFF;
      bad = 0;
      repeat (1000) begin
         @(negedge clk);
         if (fa.ADC_CS_N !== 1'b1 || fa.ADC_SCLK !== 1'b1 || fa.ADC_SADDR !== 1'b0 || busy_f !== 1'b0) bad++;
      end
      chk("idle_1000", bad, 0);

      // Single channel, constant data: priming frame then one strobe.
      do_reset();
      f_mode = 0; mask_f = 8'h01;
      addr_q.push_back(3'd0); addr_q.push_back(3'd0);
      exp_q.push_back({3'd0, 12'hABC});
      en_f = 1'b1;
      wait_cs_falls(1'b0, 2);
      repeat (5) @(negedge clk);
      en_f = 1'b0;
      wait_idle(1'b0);
      chk_queues_empty();

      // Sparse mask round-robin with per-channel data.
      do_reset();
      f_mode = 1; mask_f = 8'b1010_0100;
      addr_q.push_back(3'd2); addr_q.push_back(3'd5); addr_q.push_back(3'd7);
      addr_q.push_back(3'd2); addr_q.push_back(3'd5);
      exp_q.push_back({3'd2, 12'h102}); exp_q.push_back({3'd5, 12'h105});
      exp_q.push_back({3'd7, 12'h107}); exp_q.push_back({3'd2, 12'h102});
      en_f = 1'b1;
      wait_cs_falls(1'b0, 5);
      repeat (5) @(negedge clk);
      en_f = 1'b0;
      wait_idle(1'b0);
      chk_queues_empty();

      // Enable dropped in frame 3, then re-enabled: fresh priming frame.
      do_reset();
      mask_f = 8'h03;
      addr_q.push_back(3'd0); addr_q.push_back(3'd1); addr_q.push_back(3'd0);
      exp_q.push_back({3'd0, 12'h100}); exp_q.push_back({3'd1, 12'h101});
      en_f = 1'b1;
      wait_cs_falls(1'b0, 3);
      repeat (5) @(negedge clk);
      en_f = 1'b0;
      wait_idle(1'b0);
      chk_queues_empty();
      addr_q.push_back(3'd1); addr_q.push_back(3'd0);
      exp_q.push_back({3'd1, 12'h101});
      en_f = 1'b1;
      wait_cs_falls(1'b0, 2);
      repeat (5) @(negedge clk);
      en_f = 1'b0;
      wait_idle(1'b0);
      chk_queues_empty();

      // Reset in the middle of frame 2 (SCLK high, bit 7).
      do_reset();
      mask_f = 8'h03;
      addr_q.push_back(3'd0);
      en_f = 1'b1;
      wait_cs_falls(1'b0, 2);
      wait_sclk_rises(8);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_cs_n", fa.ADC_CS_N, 1);
      chk("midrst_sclk", fa.ADC_SCLK, 1);
      chk("midrst_saddr", fa.ADC_SADDR, 0);
      chk("midrst_busy", busy_f, 0);
      chk("midrst_valid", fa.sample_valid, 0);
      chk("midrst_sample_data", fa.sample_data, 0);
      addr_q.push_back(3'd0); addr_q.push_back(3'd1);
      exp_q.push_back({3'd0, 12'h100});
      rst = 1'b0;
      wait_cs_falls(1'b0, 2);
      repeat (5) @(negedge clk);
      en_f = 1'b0;
      wait_idle(1'b0);
      chk_queues_empty();

      // Default timing: full mask, SCLK shape and strobe spacing.
      do_reset();
      mask_d = 8'hFF;
      for (int i = 0; i < 8; i++) dexp_q.push_back(3'(i));
      en_d = 1'b1;
      wait_cs_falls(1'b1, 1);
      nf = 0; t1 = 0; t2 = 0; budget = 0;
      prev_sclk = fd.ADC_SCLK;
      while (fd.ADC_CS_N === 1'b0 && budget < 2000) begin
         @(negedge clk);
         budget++;
         if (prev_sclk === 1'b1 && fd.ADC_SCLK === 1'b0) begin
            nf++;
            if (nf == 1) t1 = cyc;
            else if (nf == 2) t2 = cyc;
         end
         prev_sclk = fd.ADC_SCLK;
      end
      chk("def_sclk_falls", nf, 16);
      chk("def_sclk_period", t2 - t1, 32);
      wait_cs_falls(1'b1, 8);
      repeat (20) @(negedge clk);
      en_d = 1'b0;
      wait_idle(1'b1);
      chk("dexp_q_empty", dexp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/adc_scan_ctrl.md
Name: adc_scan_ctrl

Overview:
- Sequencer for the on-board 8-channel, 12-bit serial ADC (ADC128S022-style SPI: CS_N, SCLK, DIN/SADDR, DOUT/SDAT).
- Scans an enabled-channel mask round-robin, runs one 16-bit SPI frame per conversion and emits a tagged 12-bit sample strobe.
- Sits between the ADC pins at top level and user logic (LED display, FIFO, processing) in the CLOCK_50 domain.

Parameters:
- CLK_DIV, 16: system clocks per SCLK half-period, min 2. 16 gives 1.5625 MHz SCLK at 50 MHz.
- CS_GAP, 8: clocks CS_N stays high between frames, min 1.

Ports:
- CLOCK_50 input 1: system clock, single domain.
- RESET input 1: synchronous, active-high reset.
- enable input 1: level; scanning runs while high.
- ch_mask input 8: bit i set means channel i is in the scan.
- ADC_CS_N output 1: ADC chip select, active low.
- ADC_SCLK output 1: serial clock, idles high.
- ADC_SADDR output 1: ADC DIN, carries the channel address.
- ADC_SDAT input 1: ADC DOUT.
- sample_valid output 1: one-cycle strobe.
- sample_ch output 3: channel of the sample.
- sample_data output 12: conversion result.
- busy output 1: high whenever the FSM is not in IDLE.

Behaviour:
- Reset is synchronous and active-high, in CLOCK_50, and takes priority over everything, including mid-frame. Next edge forces:
  - ADC_CS_N=1, ADC_SCLK=1, ADC_SADDR=0, sample_valid=0, sample_ch=0, sample_data=0, busy=0.
  - last_ch=7, prime=1, state=IDLE.
- FSM states: IDLE, CS_SETUP, SCLK_LO, SCLK_HI, CS_HOLD, GAP.
- IDLE:
  - Leaves when enable=1 and ch_mask!=0.
  - On leaving: next_ch = first set bit of ch_mask searching from (last_ch+1) mod 8 upward, wrapping. Latch it as frame_ch, drop CS_N, go to CS_SETUP.
- CS_SETUP: CLK_DIV clocks, SCLK=1, then SCLK_LO with bit index k=0.
- SCLK_LO: CLK_DIV clocks.
  - On entry SCLK falls and SADDR = address bit for k.
  - k=2,3,4 carry frame_ch[2], [1], [0]. All other k drive 0.
- SCLK_HI: CLK_DIV clocks.
  - On entry SCLK rises and SDAT is sampled into shift register bit (15-k).
  - Then k++. After k=15 go to CS_HOLD, else back to SCLK_LO.
- CS_HOLD: CLK_DIV clocks with SCLK=1, then CS_N=1, SADDR=0, go to GAP.
- Result pipeline: the ADC returns the conversion for the address sent in the previous frame.
  - At CS_HOLD exit: if prime=0, pulse sample_valid for exactly one cycle with sample_ch=prev_ch and sample_data=shift[11:0]. Upper 4 bits are ignored.
  - If prime=1, no pulse; clear prime.
  - Then prev_ch <= frame_ch and last_ch <= frame_ch.
  - sample_ch and sample_data hold their values until the next strobe.
- GAP: CS_GAP clocks.
  - If enable=1 and ch_mask!=0, select the next channel and go to CS_SETUP.
  - Else go to IDLE and set prime=1.
- ch_mask is sampled only at channel selection. Changes mid-frame do not affect the current frame.
- enable drop mid-frame: the frame completes and its pending result is still emitted. The pipelined sample of the final address is discarded.
- Single-channel mask: the same channel repeats every frame.
- Frame period: CLK_DIV*34 + CS_GAP clocks, 552 at defaults. Steady-state strobe spacing equals the frame period.
- No combinational path from inputs to outputs. All ADC pins and sample outputs are registered.

Decomposition:
- Shared package/include adc_pkg:
  - Constants ADC_NUM_CH=8, ADC_DATA_W=12, ADC_FRAME_BITS=16, ADC_ADDR_FIRST_BIT=2.
  - FSM state encodings.
- Sub-module adc_ch_sel: combinational round-robin next-enabled-channel finder.
  - Inputs: mask[7:0], last[2:0].
  - Outputs: next[2:0], any.
  - Reused for any other round-robin arbiters.

Test Plan:
- Reset hold, then release with enable=0 → CS_N=1, SCLK=1, SADDR=0, busy=0, no sample_valid for 1000 clocks.
- CLK_DIV=2, mask=8'h01, ADC model returns 12'hABC:
  - First frame SADDR bits 2-4 = 000 and no strobe.
  - Second frame ends with sample_valid=1 for one cycle, sample_ch=0, sample_data=12'hABC.
- mask=8'b1010_0100, model returns 12'h100+ch:
  - Addressed channels are 2,5,7,2,5.
  - Strobes give (2,12'h102), (5,12'h105), (7,12'h107) in order.
- enable dropped during frame 3 of a mask=8'h03 scan:
  - Frame completes, one final strobe for ch1, then IDLE with busy=0.
  - Re-enable: first frame is a priming frame with no strobe.
- RESET asserted while in SCLK_HI at k=7 → next clock CS_N=1, SCLK=1, SADDR=0, busy=0, no strobe. Resume starts at ch0 with priming.
- Defaults (CLK_DIV=16, CS_GAP=8), mask=8'hFF:
  - SCLK period 32 clocks, 16 falling edges per CS_N-low window.
  - Strobe spacing exactly 552 clocks, channels cycle 0-7.
